// File: rtl/fir_tdm.sv
// Time-division-multiplexed multi-channel FIR filter built around one shared MAC.
// Optional clamping of the output is enabled by defining FIR_TDM_SAT_EN; otherwise the output wraps.
module fir_tdm #(
  parameter int unsigned IWIDTH   = 16,
  parameter int unsigned CWIDTH   = 16,
  parameter int unsigned TAPS     = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned OWIDTH   = 16,
  parameter int unsigned SHIFT    = 15
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          coef_we,
  input  logic [$clog2(TAPS)-1:0]                       coef_addr,
  input  logic signed [CWIDTH-1:0]                      coef_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] in_ch,
  input  logic signed [IWIDTH-1:0]                      in_data,
  output logic                                          out_valid,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_ch,
  output logic signed [OWIDTH-1:0]                      out_data,
  output logic                                          out_sat
);

  localparam int unsigned KW  = $clog2(TAPS);
  localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PRW = IWIDTH + CWIDTH;
  localparam int unsigned AW  = PRW + $clog2(TAPS);
  localparam int unsigned XW  = (AW + 1 > OWIDTH) ? AW + 1 : OWIDTH + 1;
  localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [KW-1:0]         K_LAST = KW'(TAPS - 1);
  localparam logic [KW:0]           K_LIM  = (KW + 1)'(TAPS);
  localparam logic [CHW:0]          CH_LIM = (CHW + 1)'(CHANNELS);
  localparam logic signed [XW-1:0]  RND    = (SHIFT > 0) ? (XW'(1) << RSH) : '0;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e                   state_q, state_d;
  logic signed [IWIDTH-1:0] hist_q [CHANNELS][TAPS];
  logic signed [IWIDTH-1:0] hist_d [CHANNELS][TAPS];
  logic signed [CWIDTH-1:0] coef_q [TAPS];
  logic signed [CWIDTH-1:0] coef_d [TAPS];
  logic [KW-1:0]            ptr_q [CHANNELS];
  logic [KW-1:0]            ptr_d [CHANNELS];
  logic [CHW-1:0]           ch_q, ch_d;
  logic [KW-1:0]            rd_q, rd_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [CHW-1:0]           out_ch_q, out_ch_d;
  logic signed [OWIDTH-1:0] out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic                     accept_c;
  logic                     ch_ok_c;
  logic                     addr_ok_c;
  logic signed [PRW-1:0]    prod_c;
  logic signed [AW-1:0]     mac_sum_c;
  logic signed [XW-1:0]     rnd_c;
  logic signed [XW-1:0]     shf_c;
  logic signed [OWIDTH-1:0] res_c;
  logic                     res_sat_c;

  assign ch_ok_c   = {1'b0, in_ch} < CH_LIM;
  assign addr_ok_c = {1'b0, coef_addr} < K_LIM;
  assign accept_c  = (state_q == S_IDLE) && in_valid && in_ready_q && ch_ok_c;

  // Serial MAC: k_q selects the coefficient, rd_q walks the history from newest to oldest.
  assign prod_c    = coef_q[k_q] * hist_q[ch_q][rd_q];
  assign mac_sum_c = acc_q + AW'(prod_c);
  assign rnd_c     = XW'(mac_sum_c) + RND;
  assign shf_c     = rnd_c >>> SHIFT;

`ifdef FIR_TDM_SAT_EN
  localparam logic signed [XW-1:0] OMAX = {{(XW - OWIDTH + 1){1'b0}}, {(OWIDTH - 1){1'b1}}};
  localparam logic signed [XW-1:0] OMIN = {{(XW - OWIDTH + 1){1'b1}}, {(OWIDTH - 1){1'b0}}};

  always_comb begin
    res_c     = shf_c[OWIDTH-1:0];
    res_sat_c = 1'b0;
    if (shf_c > OMAX) begin
      res_c     = OMAX[OWIDTH-1:0];
      res_sat_c = 1'b1;
    end else if (shf_c < OMIN) begin
      res_c     = OMIN[OWIDTH-1:0];
      res_sat_c = 1'b1;
    end
  end
`else
  logic unused_hi_bits_c;

  assign res_c            = shf_c[OWIDTH-1:0];
  assign res_sat_c        = 1'b0;
  assign unused_hi_bits_c = ^shf_c[XW-1:OWIDTH];
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    coef_d      = coef_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    rd_d        = rd_q;
    k_d         = k_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (coef_we && addr_ok_c) begin
          coef_d[coef_addr] = coef_data;
        end
        if (accept_c) begin
          hist_d[in_ch][ptr_q[in_ch]] = in_data;
          ptr_d[in_ch] = (ptr_q[in_ch] == K_LAST) ? '0 : ptr_q[in_ch] + KW'(1);
          ch_d       = in_ch;
          rd_d       = ptr_q[in_ch];
          k_d        = '0;
          acc_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = mac_sum_c;
        rd_d  = (rd_q == '0) ? K_LAST : rd_q - KW'(1);
        k_d   = k_q + KW'(1);
        if (k_q == K_LAST) begin
          out_valid_d = 1'b1;
          out_ch_d    = ch_q;
          out_data_d  = res_c;
          out_sat_d   = res_sat_c;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        in_ready_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      rd_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          hist_q[c][t] <= '0;
        end
      end
      for (int t = 0; t < TAPS; t++) begin
        coef_q[t] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      coef_q      <= coef_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      rd_q        <= rd_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
